// File: rtl/mesi_isc_bcast_sched.sv
// Round-robin broadcast scheduler: grants one main-bus requester, then for broadcast
// commands drives snoops to the other caches followed by an enable to the initiator.
module mesi_isc_bcast_sched #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd3_i,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd2_i,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd1_i,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd0_i,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr3_i,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr2_i,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr1_i,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr0_i,
    input  logic                      cbus_ack3_i,
    input  logic                      cbus_ack2_i,
    input  logic                      cbus_ack1_i,
    input  logic                      cbus_ack0_i,
    output logic [ADDR_WIDTH-1:0]     cbus_addr_o,
    output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd3_o,
    output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd2_o,
    output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd1_o,
    output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd0_o,
    output logic                      mbus_ack3_o,
    output logic                      mbus_ack2_o,
    output logic                      mbus_ack1_o,
    output logic                      mbus_ack0_o,
    output logic                      busy_o
);

    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP      = '0;
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR       = MBUS_CMD_WIDTH'(1);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);

    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP      = '0;
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, ACK, SNOOP, EN} state_t;

    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd  [4];
    logic [ADDR_WIDTH-1:0]     mbus_addr [4];
    logic [3:0]                cbus_ack;

    assign mbus_cmd  = '{mbus_cmd0_i, mbus_cmd1_i, mbus_cmd2_i, mbus_cmd3_i};
    assign mbus_addr = '{mbus_addr0_i, mbus_addr1_i, mbus_addr2_i, mbus_addr3_i};
    assign cbus_ack  = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};

    state_t                    state, state_n;
    logic [1:0]                last_grant, last_grant_n;
    logic [1:0]                gnt_id, gnt_id_n;
    logic [MBUS_CMD_WIDTH-1:0] gnt_cmd, gnt_cmd_n;
    logic [3:0]                done_q, done_n;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_n;
    logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_q [4];
    logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_n [4];
    logic [3:0]                mbus_ack_q, mbus_ack_n;
    logic                      busy_q;

    logic [3:0]                req_vld;
    logic                      win_found;
    logic [1:0]                win_id;
    logic [1:0]                cand;
    logic [3:0]                init_mask;
    logic [CBUS_CMD_WIDTH-1:0] snoop_cmd, en_cmd;

    // Round-robin search starting one past the last granted port.
    always_comb begin
        req_vld   = '0;
        win_found = 1'b0;
        win_id    = last_grant;
        cand      = '0;
        for (int i = 0; i < 4; i++)
            req_vld[i] = (mbus_cmd[i] != MBUS_NOP) && (mbus_cmd[i] <= MBUS_RD_BROAD);
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!win_found && req_vld[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign init_mask = 4'b0001 << gnt_id;
    assign snoop_cmd = (gnt_cmd == MBUS_WR_BROAD) ? CBUS_WR_SNOOP : CBUS_RD_SNOOP;
    assign en_cmd    = (gnt_cmd == MBUS_WR_BROAD) ? CBUS_EN_WR : CBUS_EN_RD;

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        gnt_id_n     = gnt_id;
        gnt_cmd_n    = gnt_cmd;
        done_n       = done_q;
        addr_n       = addr_q;
        mbus_ack_n   = '0;
        for (int i = 0; i < 4; i++) cbus_cmd_n[i] = cbus_cmd_q[i];
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n             = ACK;
                    last_grant_n        = win_id;
                    gnt_id_n            = win_id;
                    gnt_cmd_n           = mbus_cmd[win_id];
                    addr_n              = mbus_addr[win_id];
                    mbus_ack_n[win_id]  = 1'b1;
                end
            end
            ACK: begin
                if (gnt_cmd == MBUS_WR_BROAD || gnt_cmd == MBUS_RD_BROAD) begin
                    state_n = SNOOP;
                    done_n  = '0;
                    for (int j = 0; j < 4; j++)
                        cbus_cmd_n[j] = (2'(j) == gnt_id) ? CBUS_NOP : snoop_cmd;
                end else begin
                    state_n = IDLE;
                end
            end
            SNOOP: begin
                // Acks on idle buses (including the initiator) or already-done buses are dropped.
                for (int j = 0; j < 4; j++) begin
                    if (cbus_ack[j] && cbus_cmd_q[j] != CBUS_NOP && !done_q[j]) begin
                        done_n[j]     = 1'b1;
                        cbus_cmd_n[j] = CBUS_NOP;
                    end
                end
                if ((done_n | init_mask) == 4'hF) begin
                    state_n            = EN;
                    cbus_cmd_n[gnt_id] = en_cmd;
                end
            end
            EN: begin
                if (cbus_ack[gnt_id] && cbus_cmd_q[gnt_id] != CBUS_NOP) begin
                    state_n            = IDLE;
                    cbus_cmd_n[gnt_id] = CBUS_NOP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            done_q     <= '0;
            addr_q     <= '0;
            mbus_ack_q <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < 4; i++) cbus_cmd_q[i] <= CBUS_NOP;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            done_q     <= done_n;
            addr_q     <= addr_n;
            mbus_ack_q <= mbus_ack_n;
            busy_q     <= (state_n != IDLE);
            for (int i = 0; i < 4; i++) cbus_cmd_q[i] <= cbus_cmd_n[i];
        end
    end

    // Grant bookkeeping is only consulted outside IDLE, so it needs no reset.
    always_ff @(posedge clk) begin
        gnt_id  <= gnt_id_n;
        gnt_cmd <= gnt_cmd_n;
    end

    assign cbus_addr_o = addr_q;
    assign cbus_cmd0_o = cbus_cmd_q[0];
    assign cbus_cmd1_o = cbus_cmd_q[1];
    assign cbus_cmd2_o = cbus_cmd_q[2];
    assign cbus_cmd3_o = cbus_cmd_q[3];
    assign mbus_ack0_o = mbus_ack_q[0];
    assign mbus_ack1_o = mbus_ack_q[1];
    assign mbus_ack2_o = mbus_ack_q[2];
    assign mbus_ack3_o = mbus_ack_q[3];
    assign busy_o      = busy_q;

    logic unused_wr;
    assign unused_wr = (MBUS_WR == MBUS_NOP);

endmodule
